// File: rtl/spi_regif_pkg.sv
// spi_regif_pkg: shared widths, frame geometry and FSM states for the SPI register interface
package spi_regif_pkg;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CMD_LEN   = 1 + ADDR_W;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_t;
endpackage

// File: rtl/spi_sync2.sv
// spi_sync2: two-flop synchroniser with a selectable reset level
module spi_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
        else        {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/spi_slave_regif.sv
// spi_slave_regif: SPI mode-0 slave turning 24-bit frames into register read/write strobes
module spi_slave_regif
    import spi_regif_pkg::*;
(
    input  logic              CLK_IN,
    input  logic              RST_IN,
    input  logic              SPI_SCK,
    input  logic              SPI_MOSI,
    input  logic              SPI_NSS,
    output logic              SPI_MISO,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic              frame_err
);
    logic              sck_s, mosi_s, nss_s, sck_q, nss_q;
    logic              armed, rw, re_d;
    logic [1:0]        settle;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-2:0] rx;
    logic [DATA_W-1:0] tx;
    state_t            state, state_next;
    logic              sck_rise, sck_fall, nss_rise, nss_fall;
    logic              shift, rise_cmd, rise_last, tx_shift;
    logic              re_next, we_next, err_next;

    spi_sync2 #(.RST_VAL(1'b0)) u_sync_sck  (.clk(CLK_IN), .rst_n(RST_IN), .d(SPI_SCK),  .q(sck_s));
    spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(CLK_IN), .rst_n(RST_IN), .d(SPI_MOSI), .q(mosi_s));
    spi_sync2 #(.RST_VAL(1'b1)) u_sync_nss  (.clk(CLK_IN), .rst_n(RST_IN), .d(SPI_NSS),  .q(nss_s));

    assign busy = ~nss_s;

    // edge detection, next state and strobe decisions; a frame only starts once NSS was genuinely seen high
    always_comb begin
        sck_rise   = sck_s & ~sck_q;
        sck_fall   = ~sck_s & sck_q;
        nss_rise   = nss_s & ~nss_q;
        nss_fall   = ~nss_s & nss_q & armed;
        shift      = sck_rise & ~nss_s & (state == ST_CMD || state == ST_DATA);
        rise_cmd   = shift && cnt == CNT_W'(CMD_LEN - 1);
        rise_last  = shift && cnt == CNT_W'(FRAME_LEN - 1);
        tx_shift   = sck_fall & ~nss_s & rw & (state == ST_DATA);
        re_next    = rise_cmd & rx[CMD_LEN-2];
        we_next    = rise_last & ~rw;
        err_next   = nss_rise && (state == ST_CMD || state == ST_DATA) && cnt != '0;
        state_next = nss_s                          ? ST_IDLE :
                     state == ST_IDLE               ? (nss_fall ? ST_CMD : ST_IDLE) :
                     state == ST_CMD  && rise_cmd   ? ST_DATA :
                     state == ST_DATA && rise_last  ? ST_DONE : state;
    end

    // state register
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) state <= ST_IDLE;
        else         state <= state_next;
    end

    // shift registers, counter, strobes and serial output
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            sck_q     <= 1'b0;
            nss_q     <= 1'b1;
            settle    <= '0;
            armed     <= 1'b0;
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            rw        <= 1'b0;
            re_d      <= 1'b0;
            reg_re    <= 1'b0;
            reg_we    <= 1'b0;
            frame_err <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            SPI_MISO  <= 1'b0;
        end else begin
            sck_q     <= sck_s;
            nss_q     <= nss_s;
            settle    <= {settle[0], 1'b1};
            armed     <= armed | (settle[1] & nss_s);
            reg_re    <= re_next;
            reg_we    <= we_next;
            frame_err <= err_next;
            re_d      <= reg_re;
            if (nss_fall) begin
                cnt <= '0;
                rx  <= '0;
            end else if (shift) begin
                cnt <= cnt + 1'b1;
                rx  <= {rx[DATA_W-3:0], mosi_s};
            end
            if (nss_fall)      tx <= '0;
            else if (re_d)     tx <= reg_rdata;
            else if (tx_shift) tx <= {tx[DATA_W-2:0], 1'b0};
            if (rise_cmd) begin
                rw       <= rx[CMD_LEN-2];
                reg_addr <= {rx[ADDR_W-2:0], mosi_s};
            end
            if (we_next) reg_wdata <= {rx, mosi_s};
            SPI_MISO <= (nss_s || state == ST_IDLE)     ? 1'b0 :
                        tx_shift                         ? tx[DATA_W-1] :
                        (sck_fall && state == ST_DONE)   ? 1'b0 : SPI_MISO;
        end
    end
endmodule
